// File: rtl/pilot_insert.sv
// OFDM subcarrier mapper: interleaves accepted data samples with generated
// pilots and nulls according to a per-subcarrier allocation map.
module pilot_insert #(
  parameter int unsigned NSC       = 200,
  parameter logic [15:0] PILOT_AMP = 16'h2000,
  parameter bit          PRBS_EN   = 1'b1
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [31:0]      DAT_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  output logic             ACK_O,
  output logic [31:0]      DAT_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I,
  input  logic [2*NSC-1:0] ALLOC_VEC,
  input  logic             VEC_LD
);

  localparam int unsigned   KW        = (NSC > 1) ? $clog2(NSC) : 1;
  localparam logic [KW-1:0] K_LAST    = KW'(NSC - 1);
  localparam logic [10:0]   PRBS_SEED = 11'h7FF;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [10:0]      lfsr;
  logic [2*NSC-1:0] alloc;
  logic [2*NSC-1:0] pend_vec;
  logic             pend;
  logic [31:0]      dat_q;
  logic             stb_q;
  logic             cyc_q;

  logic [1:0]  code;
  logic        can_load;
  logic        in_xfer;
  logic        at_end;
  logic        load;
  logic        wrap;
  logic        w;
  logic        neg;
  logic [15:0] pil_re;
  logic [31:0] gen_val;

  always_comb begin
    code     = alloc[{k, 1'b0} +: 2];
    can_load = !stb_q || ACK_I;
    ACK_O    = (state == RUN) && (code == 2'b11) && can_load;
    in_xfer  = CYC_I && STB_I && WE_I && ACK_O;
    // A frame ends only at a symbol boundary: k back at 0 with the upstream idle.
    at_end   = (state == RUN) && (k == '0) && !CYC_I;
    load     = (state == RUN) && can_load && !at_end && ((code == 2'b11) ? in_xfer : 1'b1);
    wrap     = load && (k == K_LAST);
    // The 7FF seed has tap XOR 0, so the first symbol of a frame is unmodified.
    w        = PRBS_EN && (lfsr[10] ^ lfsr[8]);
    neg      = code[1] ^ w;
    pil_re   = neg ? (~PILOT_AMP + 16'd1) : PILOT_AMP;
    gen_val  = '0;
    case (code)
      2'b11:          gen_val = DAT_I;
      2'b01, 2'b10:   gen_val = {16'h0000, pil_re};
      default:        gen_val = '0;
    endcase
  end

  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  assign CYC_O = cyc_q;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= IDLE;
      k        <= '0;
      lfsr     <= PRBS_SEED;
      alloc    <= '0;
      pend_vec <= '0;
      pend     <= 1'b0;
      dat_q    <= '0;
      stb_q    <= 1'b0;
      cyc_q    <= 1'b0;
    end else begin
      // A load coinciding with the wrap lands directly and supersedes any pending map.
      if (VEC_LD) begin
        if (state == IDLE || (k == '0 && !load) || wrap) begin
          alloc <= ALLOC_VEC;
          pend  <= 1'b0;
        end else begin
          pend_vec <= ALLOC_VEC;
          pend     <= 1'b1;
        end
      end else if (wrap && pend) begin
        alloc <= pend_vec;
        pend  <= 1'b0;
      end

      if (load) begin
        dat_q <= gen_val;
        stb_q <= 1'b1;
        cyc_q <= 1'b1;
      end else if (ACK_I) begin
        stb_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (CYC_I) begin
            state <= RUN;
            k     <= '0;
            lfsr  <= PRBS_SEED;
          end
        end
        RUN: begin
          if (load) begin
            k <= wrap ? '0 : k + 1'b1;
          end
          if (wrap) begin
            lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
          end
          if (at_end) begin
            state <= FLUSH;
            if (can_load) begin
              cyc_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (can_load) begin
            state <= IDLE;
            cyc_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pilot_insert.sv
// Directed bench for pilot_insert: the driver queues each expected subcarrier,
// an independent monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_pilot_insert;

  localparam int unsigned NSC  = 200;
  localparam int unsigned TO   = 400;
  localparam logic [31:0] PPOS = 32'h0000_2000;
  localparam logic [31:0] PNEG = 32'h0000_E000;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             cyc_i     = 1'b0;
  logic             stb_i     = 1'b0;
  logic             we_i      = 1'b0;
  logic             ack_i     = 1'b1;
  logic             vec_ld    = 1'b0;
  logic [31:0]      dat_i     = '0;
  logic [2*NSC-1:0] alloc_vec = '0;
  logic             ack_o, cyc_o, stb_o, we_o;
  logic [31:0]      dat_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_pop = 0;
  logic [31:0] sb[$];
  logic        bp_en     = 1'b0;
  logic        chk_first = 1'b0;
  int          hook_ld   = -1;
  int          hook_gap  = -1;
  int          hook_rst  = -1;
  logic [2*NSC-1:0] v_std, v_tail, v_all;

  always #5 clk = ~clk;

  pilot_insert #(.NSC(NSC), .PILOT_AMP(16'h2000), .PRBS_EN(1'b1)) dut (
    .CLK_I(clk), .RST_I(rst), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i),
    .WE_I(we_i), .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o),
    .WE_O(we_o), .ACK_I(ack_i), .ALLOC_VEC(alloc_vec), .VEC_LD(vec_ld)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // kind 0: 802.16-style map, 1: same with pilot/pilot/null/null tail, 2: all data
  function automatic logic [2*NSC-1:0] mk_vec(input int unsigned kind);
    logic [2*NSC-1:0] v;
    logic [1:0] c;
    v = '0;
    for (int unsigned k = 0; k < NSC; k++) begin
      c = 2'b11;
      if (kind != 2) begin
        if (k == 12 || k == 62 || k == 112 || k == 162) c = 2'b01;
        if (k == 37 || k == 87 || k == 137 || k == 187) c = 2'b10;
        if (kind == 1) begin
          if (k == 196) c = 2'b01;
          if (k == 197) c = 2'b10;
          if (k >= 198) c = 2'b00;
        end
      end
      v[2*k +: 2] = c;
    end
    return v;
  endfunction

  function automatic logic [31:0] pilot_val(input logic [1:0] c, input bit w);
    case (c)
      2'b01:   return w ? PNEG : PPOS;
      2'b10:   return w ? PPOS : PNEG;
      default: return 32'h0;
    endcase
  endfunction

  // w sequence of x^11+x^9+1 from seed 7FF: zero for symbols 0..8, one for 9 and 10
  function automatic bit w_of(input int unsigned s);
    return (s == 9 || s == 10);
  endfunction

  initial begin
    int unsigned ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        ack_i = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        ack_i = 1'b1;
      end
    end
  end

  initial begin
    logic        prev_stall;
    logic [31:0] prev_dat;
    logic [31:0] exp_v;
    prev_stall = 1'b0;
    prev_dat   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_stb", 32'(stb_o), 32'd1);
          check("hold_dat", dat_o, prev_dat);
        end
        if (stb_o) begin
          check("we_eq_stb", 32'(we_o), 32'd1);
          check("cyc_with_stb", 32'(cyc_o), 32'd1);
          if (!ack_i) begin
            check("ack_o_stall", 32'(ack_o), 32'd0);
          end else if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got %h, expected no output", dat_o);
          end else begin
            exp_v = sb.pop_front();
            n_pop++;
            check("dat_o", dat_o, exp_v);
          end
        end
        prev_stall = stb_o && !ack_i;
        prev_dat   = dat_o;
      end
    end
  end

  task automatic send(input logic [31:0] d);
    bit done;
    done  = 1'b0;
    stb_i = 1'b1;
    dat_i = d;
    for (int unsigned t = 0; t < TO && !done; t++) begin
      @(negedge clk);
      done = ack_o && cyc_i;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no ACK_O, expected accept of %h", d);
    end
    @(posedge clk); #1;
    stb_i = 1'b0;
  endtask

  task automatic load_vec(input logic [2*NSC-1:0] v);
    alloc_vec = v;
    vec_ld    = 1'b1;
    @(posedge clk); #1;
    vec_ld    = 1'b0;
  endtask

  task automatic run_symbol(input logic [2*NSC-1:0] vec, input bit w, input logic [31:0] base,
                            input bit drop, output bit aborted);
    int last_data;
    logic [1:0] c;
    aborted   = 1'b0;
    last_data = -1;
    for (int k = 0; k < NSC; k++) if (vec[2*k +: 2] == 2'b11) last_data = k;
    for (int k = 0; k < NSC; k++) begin
      if (k == hook_ld) begin
        alloc_vec = v_all;
        vec_ld    = 1'b1;
        @(posedge clk); #1;
        vec_ld    = 1'b0;
      end
      if (k == hook_gap) begin
        cyc_i = 1'b0;
        for (int g = 0; g < 5; g++) begin
          @(negedge clk);
          check("gap_cyc_o", 32'(cyc_o), 32'd1);
        end
        check("gap_k_hold", 32'(stb_o), 32'd0);
        @(posedge clk); #1;
        cyc_i = 1'b1;
      end
      if (k == hook_rst) begin
        rst   = 1'b1;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        @(posedge clk); #1;
        rst   = 1'b0;
        @(negedge clk);
        check("rst_ack_o", 32'(ack_o), 32'd0);
        check("rst_stb_o", 32'(stb_o), 32'd0);
        check("rst_we_o",  32'(we_o),  32'd0);
        check("rst_cyc_o", 32'(cyc_o), 32'd0);
        check("rst_dat_o", dat_o, 32'h0);
        sb.delete();
        for (int g = 0; g < 4; g++) begin
          @(negedge clk);
          check("post_rst_stb", 32'(stb_o), 32'd0);
        end
        @(posedge clk); #1;
        aborted = 1'b1;
        return;
      end
      c = vec[2*k +: 2];
      if (c == 2'b11) begin
        sb.push_back(base + 32'(k));
        send(base + 32'(k));
        if (chk_first) begin
          chk_first = 1'b0;
          @(negedge clk);
          check("first_stb", 32'(stb_o), 32'd1);
          check("first_dat", dat_o, base + 32'(k));
          @(posedge clk); #1;
        end
        if (drop && k == last_data) cyc_i = 1'b0;
      end else begin
        sb.push_back(pilot_val(c, w));
      end
    end
  endtask

  task automatic end_frame(input int unsigned n_exp, input string name);
    bit done;
    done = 1'b0;
    for (int unsigned t = 0; t < 4*TO && !done; t++) begin
      @(posedge clk);
      done = (sb.size() == 0);
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: got %0d queued, expected 0", name, sb.size());
    end
    @(negedge clk);
    check({name, "_cyc_fall"}, 32'(cyc_o), 32'd0);
    check({name, "_count"}, n_pop, n_exp);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    v_std  = mk_vec(0);
    v_tail = mk_vec(1);
    v_all  = mk_vec(2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack_o", 32'(ack_o), 32'd0);
    check("reset_stb_o", 32'(stb_o), 32'd0);
    check("reset_we_o",  32'(we_o),  32'd0);
    check("reset_cyc_o", 32'(cyc_o), 32'd0);
    check("reset_dat_o", dat_o, 32'h0);
    @(posedge clk); #1;
    rst  = 1'b0;
    we_i = 1'b1;

    // nominal symbol
    load_vec(v_std);
    n_pop = 0; chk_first = 1'b1; cyc_i = 1'b1;
    run_symbol(v_std, 1'b0, 32'h0, 1'b1, ab);
    end_frame(NSC, "nominal");

    // backpressure
    load_vec(v_std);
    bp_en = 1'b1; n_pop = 0; cyc_i = 1'b1;
    run_symbol(v_std, 1'b0, 32'h1000_0000, 1'b1, ab);
    end_frame(NSC, "bp");
    bp_en = 1'b0;

    // pilot sign sequence over 11 symbols
    load_vec(v_std);
    n_pop = 0; cyc_i = 1'b1;
    for (int unsigned s = 0; s < 11; s++)
      run_symbol(v_std, w_of(s), 32'h2000_0000 + 32'(s*NSC), s == 10, ab);
    end_frame(11*NSC, "prbs");

    // mid-symbol map load
    load_vec(v_std);
    n_pop = 0; cyc_i = 1'b1; hook_ld = 100;
    run_symbol(v_std, 1'b0, 32'h3000_0000, 1'b0, ab);
    hook_ld = -1;
    run_symbol(v_all, 1'b0, 32'h3100_0000, 1'b1, ab);
    end_frame(2*NSC, "vecld");

    // CYC_I gap then reset mid-symbol
    load_vec(v_std);
    n_pop = 0; cyc_i = 1'b1; hook_gap = 50; hook_rst = 120;
    run_symbol(v_std, 1'b0, 32'h4000_0000, 1'b0, ab);
    hook_gap = -1; hook_rst = -1;
    check("rst_aborted", 32'(ab), 32'd1);

    // frame end with trailing pilots and nulls
    load_vec(v_tail);
    n_pop = 0; cyc_i = 1'b1;
    run_symbol(v_tail, 1'b0, 32'h7000_0000, 1'b1, ab);
    end_frame(NSC, "tail");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pilot_insert.md
PILOT_INSERT -- requirements
Module: pilot_insert

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NSC, 200, used subcarriers per OFDM symbol.
- PILOT_AMP, 16'h2000, pilot real amplitude (signed Q2.13, +1.0).
- PRBS_EN, 1, 1 = per-symbol pilot sign modulation enabled.

REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK_I, in, 1, the block's single clock.
- RST_I, in, 1, synchronous active-high reset.
- DAT_I, in, 32, data sample as {Im[31:16], Re[15:0]}, signed.
- CYC_I, in, 1, upstream frame active.
- STB_I, in, 1, input strobe.
- WE_I, in, 1, input write.
- ACK_O, out, 1, input sample accepted.
- DAT_O, out, 32, mapped subcarrier as {Im, Re}.
- CYC_O, out, 1, output frame active.
- STB_O, out, 1, output valid.
- WE_O, out, 1, output write; always equals STB_O.
- ACK_I, in, 1, downstream accept.
- ALLOC_VEC, in, 2*NSC, per-subcarrier code.
  - Bits [2k+1:2k] hold subcarrier k.
  - 11 = data, 01 = +pilot, 10 = -pilot, 00 = null.
- VEC_LD, in, 1, one-cycle pulse that loads ALLOC_VEC.

REQ-003 The clock is CLK_I. Reset is RST_I, synchronous and active-high, sampled only on the rising edge of CLK_I.

Function
REQ-004 Input and output transfers.
- An input transfer occurs on a cycle where CYC_I & STB_I & WE_I & ACK_O are all 1.
- An output transfer occurs on a cycle where STB_O & ACK_I are both 1.

REQ-005 The block holds a subcarrier index k, running 0..NSC-1. k advances by one each time a subcarrier is loaded into the output register. k wraps from NSC-1 to 0, which marks a symbol boundary.

REQ-006 Subcarrier code 11 (data).
- ACK_O = 1 only in RUN, and only when the output register is empty or ACK_I = 1.
- DAT_I is registered to DAT_O unmodified, one cycle after the input transfer.

REQ-007 Subcarrier codes 01, 10 and 00.
- ACK_O = 0; no input is consumed.
- A generated value is loaded into the output register under the same empty-or-ACK_I condition.
- Pilot value = {16'h0000, ±PILOT_AMP}. The sign is the code's sign times s, where s = -1 if w = 1, else +1.
- Null value = 32'h0.

REQ-008 Pilot PRBS.
- 11-bit LFSR, polynomial x^11+x^9+1, seeded 11'h7FF.
- w = stage11 XOR stage9. w is fed back and shifted once per symbol boundary.
- The first symbol of a frame uses w = 0.
- When PRBS_EN = 0, w is forced to 0.

REQ-009 State machine, states IDLE, RUN, FLUSH.
- IDLE -> RUN when CYC_I = 1. On this transition k is set to 0 and the PRBS is reseeded.
- RUN -> FLUSH when a symbol boundary is reached with CYC_I = 0.
- FLUSH -> IDLE once the output register is empty.

REQ-010 CYC_I drops mid-symbol: the block stalls on the next data subcarrier, holding k. CYC_O stays 1. The symbol resumes when CYC_I returns.

REQ-011 Output hold rules.
- CYC_O = 1 from the first STB_O of a frame until the cycle after the final output transfer in FLUSH.
- While STB_O = 1 and ACK_I = 0, DAT_O and STB_O are held stable.
- Full throughput is one sample per clock.

REQ-012 ALLOC_VEC loading.
- ALLOC_VEC is sampled into an internal register only on VEC_LD = 1.
- In IDLE, or at k = 0 before the first subcarrier of a symbol, the load is immediate.
- Otherwise a pending flag is set, and the load applies at the next symbol boundary.
- If VEC_LD arrives again while pending, the latest ALLOC_VEC value is used.

REQ-013 A load and a symbol boundary in the same cycle: the new vector is used for the next symbol. The pending flag is cleared.

Reset
REQ-014 On RST_I = 1, the block resets as follows.
- Outputs: ACK_O = 0, STB_O = 0, WE_O = 0, CYC_O = 0, DAT_O = 0.
- Internal state: state = IDLE, k = 0, PRBS = 11'h7FF, pending flag = 0, internal vector = all 00 (null).

REQ-015 RST_I asserted mid-symbol aborts the frame immediately. No further output transfer occurs until a new frame starts.

Verification
REQ-016 The bench shall cover the following directed scenarios.
- Nominal symbol:
  - Stimulus: 802.16 vector (192 data, pilots at the standard 8 positions: 01 at k=12,62,112,162 and 10 at k=37,87,137,187 style), ACK_I = 1, one symbol of DAT_I = index counter.
  - Required response: 200 outputs; data in order; pilots = 32'h0000_2000 or 32'h0000_E000; first DAT_O one cycle after the first ACK_O.
- Backpressure:
  - Stimulus: ACK_I toggled 1,0,0,1 repeatedly.
  - Required response: DAT_O stable while stalled; no samples lost or duplicated; ACK_O low during stalls when the register is full.
- PRBS:
  - Stimulus: 3 consecutive symbols.
  - Required response: symbol 0 pilots unmodified; later symbols' pilot signs match the w sequence from seed 7FF.
- Mid-symbol VEC_LD:
  - Stimulus: VEC_LD at k=100 with all-11 vector.
  - Required response: the current symbol keeps the old map; the next symbol is all data.
- CYC_I gap and reset:
  - Stimulus: CYC_I low for 5 cycles at k=50.
  - Required response: k holds at 50; CYC_O stays 1.
  - Stimulus: RST_I at k=120.
  - Required response: all outputs 0 on the next cycle; state IDLE.
- Frame end:
  - Stimulus: CYC_I drops after the symbol's last data sample.
  - Required response: trailing pilots and nulls are still emitted; CYC_O falls one cycle after the last output transfer.
